// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and CRC-16-CCITT constants for the ccff chain loader.
// The serial CRC step lives here so both CRC instances use one definition.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    CMP   = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One serial step: MSB-first, no reflection, no final XOR.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration stream and serial chain signals between the bitstream side
// (source plus ccff chain) and the loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              shift_en;

  // Bitstream source and chain side.
  modport master (
    output cfg_data,
    output cfg_valid,
    output ccff_tail,
    input  cfg_ready,
    input  ccff_head,
    input  shift_en
  );

  // Loader side.
  modport slave (
    input  cfg_data,
    input  cfg_valid,
    input  ccff_tail,
    output cfg_ready,
    output ccff_head,
    output shift_en
  );
endinterface

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator; clr has priority and reloads the seed.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge prog_clk) begin
    if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_next(crc, din);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a ccff chain serially from a word stream, then recirculates it once
// and compares CRCs of the loaded and read-back bit sequences.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 52,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  ccff_chain_loader_if.slave   cfg,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     bit_count
);

  localparam int               REM_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [REM_W-1:0] FULL     = REM_W'(WORD_W);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [REM_W-1:0]  rem_q, rem_d;     // unshifted bits left in word_q
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              head_q, head_d;
  logic              pass_q, pass_d;

  logic              ready;
  logic              shift;
  logic              head;
  logic              last_shift;
  logic              crc_clr;
  logic              ld_en;
  logic              rb_en;
  logic              match;
  logic [15:0]       crc_ld;
  logic [15:0]       crc_rb;

  assign cfg.cfg_ready = ready;
  assign cfg.shift_en  = shift;
  assign cfg.ccff_head = head;
  assign bit_count     = cnt_q;
  assign match         = (crc_rb == crc_ld);

  ccff_crc16_serial u_crc_loaded (
    .prog_clk (prog_clk),
    .clr      (crc_clr),
    .en       (ld_en),
    .din      (word_q[0]),
    .crc      (crc_ld)
  );

  ccff_crc16_serial u_crc_readback (
    .prog_clk (prog_clk),
    .clr      (crc_clr),
    .en       (rb_en),
    .din      (cfg.ccff_tail),
    .crc      (crc_rb)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the word buffer is small, so it is reset along with its occupancy
  // count; only rem_q actually matters for correctness.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      word_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      head_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      word_q <= word_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      pass_q <= pass_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    pass_d     = pass_q;
    ready      = 1'b0;
    shift      = 1'b0;
    head       = head_q;
    last_shift = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = pass_q;
    crc_clr    = pReset;
    ld_en      = 1'b0;
    rb_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          rem_d   = '0;
          pass_d  = 1'b0;
          crc_clr = 1'b1;
        end
      end

      LOAD: begin
        busy = 1'b1;
        if (rem_q != '0) begin
          shift      = 1'b1;
          head       = word_q[0];
          head_d     = word_q[0];
          ld_en      = 1'b1;
          word_d     = word_q >> 1;
          rem_d      = rem_q - REM_W'(1);
          cnt_d      = cnt_q + CNT_W'(1);
          last_shift = (cnt_q == LAST_BIT);
        end
        // Refill in the same cycle the last buffered bit leaves, but never
        // take a word once the chain is full.
        ready = !last_shift && ((rem_q == '0) || (rem_q == REM_W'(1)));
        if (cfg.cfg_valid && ready) begin
          word_d = cfg.cfg_data;
          rem_d  = FULL;
        end
        if (last_shift) begin
          state_d = CHECK;
          cnt_d   = '0;
          word_d  = '0;
          rem_d   = '0;
        end
      end

      CHECK: begin
        busy   = 1'b1;
        shift  = 1'b1;
        head   = cfg.ccff_tail;
        head_d = cfg.ccff_tail;
        rb_en  = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = CMP;
        end
      end

      CMP: begin
        busy    = 1'b1;
        done    = 1'b1;
        pass    = match;
        pass_d  = match;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: two loaders (52-bit and 32-bit chains) driving behavioural
// chain models; cycle numbers count posedges after the cycle start is raised.
module tb_ccff_chain_loader;

  localparam int LEN_A = 52;
  localparam int LEN_B = 32;
  localparam int WW    = 32;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  logic start_a  = 1'b0;
  logic start_b  = 1'b0;
  logic busy_a, done_a, pass_a;
  logic busy_b, done_b, pass_b;
  logic [5:0] bc_a, bc_b;

  ccff_chain_loader_if #(.WORD_W(WW)) if_a ();
  ccff_chain_loader_if #(.WORD_W(WW)) if_b ();

  ccff_chain_loader #(.CHAIN_LEN(LEN_A), .WORD_W(WW)) dut_a (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start_a),
    .cfg       (if_a.slave),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .bit_count (bc_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(LEN_B), .WORD_W(WW)) dut_b (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start_b),
    .cfg       (if_b.slave),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .bit_count (bc_b)
  );

  always #5 prog_clk = ~prog_clk;

  int checks = 0;
  int errors = 0;

  logic [LEN_A-1:0] chain_a = '0;
  logic [LEN_B-1:0] chain_b = '0;
  int shift_a = 0, acc_a = 0, done_cnt_a = 0, flip_at = -1;
  int shift_b = 0, acc_b = 0;

  assign if_a.ccff_tail = chain_a[LEN_A-1];
  assign if_b.ccff_tail = chain_b[LEN_B-1];

  // Chain models: position 0 is the head flop; flip_at corrupts one bit.
  always @(posedge prog_clk) begin : model_a
    logic [LEN_A-1:0] nxt;
    if (if_a.shift_en) begin
      nxt = {chain_a[LEN_A-2:0], if_a.ccff_head};
      if (shift_a == flip_at) nxt[17] = ~nxt[17];
      chain_a <= nxt;
      shift_a <= shift_a + 1;
    end
    if (if_a.cfg_valid && if_a.cfg_ready) acc_a <= acc_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  always @(posedge prog_clk) begin : model_b
    if (if_b.shift_en) begin
      chain_b <= {chain_b[LEN_B-2:0], if_b.ccff_head};
      shift_b <= shift_b + 1;
    end
    if (if_b.cfg_valid && if_b.cfg_ready) acc_b <= acc_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First-shifted stream bit ends up at the tail end of the chain.
  function automatic logic [LEN_A-1:0] exp_chain(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0]      s;
    logic [LEN_A-1:0] r;
    s = {w1, w0};
    for (int i = 0; i < LEN_A; i++) r[i] = s[LEN_A-1-i];
    return r;
  endfunction

  task automatic wait_accept_a();
    int t = 0;
    while (!if_a.cfg_ready && t < 300) begin
      @(negedge prog_clk);
      t++;
    end
    @(negedge prog_clk);
  endtask

  task automatic run_op(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                        input int gap, input int flip_rel, input int restart_cyc,
                        input int exp_done, input logic exp_pass, input int exp_stall);
    int   base_sh, base_acc, cyc, done_cyc, stall;
    logic pass_seen;
    logic [5:0] bc20, bc_done;
    @(negedge prog_clk);
    base_sh  = shift_a;
    base_acc = acc_a;
    flip_at  = (flip_rel >= 0) ? base_sh + flip_rel : -1;
    start_a  = 1'b1;
    cyc = 0; done_cyc = -1; stall = 0; pass_seen = 1'bx; bc20 = '1; bc_done = '1;
    fork
      begin
        if_a.cfg_data  = w0;
        if_a.cfg_valid = 1'b1;
        wait_accept_a();
        if (gap > 0) begin
          if_a.cfg_valid = 1'b0;
          for (int t = 0; t < 300 && !if_a.cfg_ready; t++) @(negedge prog_clk);
          repeat (gap) @(negedge prog_clk);
        end
        if_a.cfg_data  = w1;
        if_a.cfg_valid = 1'b1;
        wait_accept_a();
        if_a.cfg_data  = 32'hDEAD_BEEF;
      end
      begin
        while (done_cyc < 0 && cyc < 400) begin
          @(posedge prog_clk);
          cyc++;
          #1;
          if (cyc == 1) start_a = 1'b0;
          if (cyc == restart_cyc) start_a = 1'b1;
          if (cyc == restart_cyc + 1) start_a = 1'b0;
          if (cyc == 20) bc20 = bc_a;
          if (busy_a && !if_a.shift_en && !done_a) stall++;
          if (done_a) begin
            done_cyc  = cyc;
            pass_seen = pass_a;
            bc_done   = bc_a;
          end
        end
      end
    join
    if_a.cfg_valid = 1'b0;
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, " pass"}, 64'(pass_seen), 64'(exp_pass));
    check({tag, " shifts"}, 64'(shift_a - base_sh), 64'(2 * LEN_A));
    check({tag, " accepts"}, 64'(acc_a - base_acc), 64'd2);
    check({tag, " stall_cycles"}, 64'(stall), 64'(exp_stall));
    check({tag, " bit_count@20"}, 64'(bc20), 64'd18);
    check({tag, " bit_count@done"}, 64'(bc_done), 64'(LEN_A));
    if (exp_pass) check({tag, " chain"}, 64'(chain_a), 64'(exp_chain(w0, w1)));
    @(posedge prog_clk);
    #1;
    check({tag, " busy_after"}, 64'(busy_a), 64'd0);
    check({tag, " done_after"}, 64'(done_a), 64'd0);
    flip_at = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int dn_base;
    int cyc;
    int done_cyc;
    logic pass_seen;

    if_a.cfg_data = '0; if_a.cfg_valid = 1'b0;
    if_b.cfg_data = '0; if_b.cfg_valid = 1'b0;

    // Reset with start held high at the same time: reset must win.
    pReset  = 1'b1;
    start_a = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1;
    check("rst busy", 64'(busy_a), 64'd0);
    check("rst done", 64'(done_a), 64'd0);
    check("rst pass", 64'(pass_a), 64'd0);
    check("rst shift_en", 64'(if_a.shift_en), 64'd0);
    check("rst cfg_ready", 64'(if_a.cfg_ready), 64'd0);
    check("rst ccff_head", 64'(if_a.ccff_head), 64'd0);
    check("rst bit_count", 64'(bc_a), 64'd0);
    check("rst busy_b", 64'(busy_b), 64'd0);
    @(negedge prog_clk);
    pReset  = 1'b0;
    start_a = 1'b0;
    @(posedge prog_clk);
    #1;
    check("idle after rst busy", 64'(busy_a), 64'd0);

    run_op("nominal", 32'hA5A5_0F0F, 32'h0000_0C3C, 0, -1, -1, 106, 1'b1, 1);
    run_op("stall",   32'hA5A5_0F0F, 32'h0000_0C3C, 5, -1, -1, 111, 1'b1, 6);
    run_op("fault",   32'h1234_5678, 32'h0009_ABCD, 0, 60, -1, 106, 1'b0, 1);

    // Abort mid-LOAD once 20 bits have gone in.
    @(negedge prog_clk);
    start_a = 1'b1;
    if_a.cfg_data  = 32'hCAFE_F00D;
    if_a.cfg_valid = 1'b1;
    @(negedge prog_clk);
    start_a = 1'b0;
    t = 0;
    while (bc_a != 6'd20 && t < 100) begin
      @(posedge prog_clk);
      #1;
      t++;
    end
    check("abort reached bit_count 20", 64'(bc_a), 64'd20);
    dn_base = done_cnt_a;
    pReset  = 1'b1;
    @(posedge prog_clk);
    #1;
    check("abort busy", 64'(busy_a), 64'd0);
    check("abort shift_en", 64'(if_a.shift_en), 64'd0);
    check("abort cfg_ready", 64'(if_a.cfg_ready), 64'd0);
    check("abort done", 64'(done_a), 64'd0);
    pReset = 1'b0;
    if_a.cfg_valid = 1'b0;
    repeat (4) @(posedge prog_clk);
    #1;
    check("abort no done pulse", 64'(done_cnt_a - dn_base), 64'd0);
    run_op("reload", 32'h0F1E_2D3C, 32'h000F_5A69, 0, -1, -1, 106, 1'b1, 1);

    // Start pulsed during CHECK must not disturb the operation.
    run_op("start_in_check", 32'h8000_0001, 32'h000A_AAAA, 0, -1, 70, 106, 1'b1, 1);

    // 32-bit chain, 32-bit word: exactly one word, nothing discarded.
    @(negedge prog_clk);
    start_b = 1'b1;
    if_b.cfg_data  = 32'hFFFF_FFFF;
    if_b.cfg_valid = 1'b1;
    cyc = 0; done_cyc = -1; pass_seen = 1'bx;
    while (done_cyc < 0 && cyc < 300) begin
      @(posedge prog_clk);
      cyc++;
      #1;
      if (cyc == 1) start_b = 1'b0;
      if (cyc == 2) if_b.cfg_data = 32'h0000_0000;
      if (done_b) begin
        done_cyc  = cyc;
        pass_seen = pass_b;
      end
    end
    if_b.cfg_valid = 1'b0;
    check("edge done_cycle", 64'(done_cyc), 64'd66);
    check("edge pass", 64'(pass_seen), 64'd1);
    check("edge accepts", 64'(acc_b), 64'd1);
    check("edge shifts", 64'(shift_b), 64'd64);
    check("edge chain", 64'(chain_b), 64'h0000_0000_FFFF_FFFF);
    @(posedge prog_clk);
    #1;
    check("edge busy_after", 64'(busy_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
